// File: rtl/ht_clear_ctrl_pkg.sv
// ht_clear_ctrl_pkg: shared types and defaults for the hash table clear controller.
//   ht_clear_state_t        - sequencing states of the clear controller
//   HT_INFLIGHT_WIDTH_DEF   - default width of the outstanding-task counter
package ht_clear_ctrl_pkg;

  localparam int unsigned HT_INFLIGHT_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    CLR_START = 2'd0,
    WAIT_CLR  = 2'd1,
    RUN       = 2'd2,
    DRAIN     = 2'd3
  } ht_clear_state_t;

endpackage

// File: rtl/ht_clear_ctrl_if.sv
// ht_clear_ctrl_if: task handshake between the external task source, the clear
// controller and the calc_hash stage, plus the result-accepted strobe.
//   task_valid_i / task_ready_o : upstream side (ready is gated by the controller)
//   task_valid_o / task_ready_i : calc_hash side (valid is gated by the controller)
//   res_fire_i                  : result accepted at ht_res_out (valid & ready)
// The slave modport is the controller's view; master is the environment's view.
interface ht_clear_ctrl_if;

  logic task_valid_i;
  logic task_ready_o;
  logic task_valid_o;
  logic task_ready_i;
  logic res_fire_i;

  modport slave (
    input  task_valid_i,
    input  task_ready_i,
    input  res_fire_i,
    output task_ready_o,
    output task_valid_o
  );

  modport master (
    output task_valid_i,
    output task_ready_i,
    output res_fire_i,
    input  task_ready_o,
    input  task_valid_o
  );

endinterface

// File: rtl/ht_clear_ctrl.sv
// ht_clear_ctrl: sequences head/data table clears after reset and on runtime
// clear requests, gating the task stream while a clear is in progress and
// counting outstanding tasks so a runtime clear can drain the pipeline first.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   task_if (slave)       - gated task handshake and result-accepted strobe
//   clear_req_i           - runtime clear request (sampled only in RUN)
//   head/data_clear_run_o - one-cycle clear start pulses to the tables
//   head/data_clear_done_i- clear completion from the tables (pulse or level)
//   init_done_o           - first clear after reset has completed (sticky)
//   busy_o                - controller is not in RUN
//   inflight_o            - outstanding task count
//   underflow_o           - sticky: result seen with no outstanding task
module ht_clear_ctrl
  import ht_clear_ctrl_pkg::*;
#(
  parameter int unsigned INFLIGHT_WIDTH = HT_INFLIGHT_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  ht_clear_ctrl_if.slave            task_if,
  input  logic                      clear_req_i,
  output logic                      head_clear_run_o,
  input  logic                      head_clear_done_i,
  output logic                      data_clear_run_o,
  input  logic                      data_clear_done_i,
  output logic                      init_done_o,
  output logic                      busy_o,
  output logic [INFLIGHT_WIDTH-1:0] inflight_o,
  output logic                      underflow_o
);

  localparam logic [INFLIGHT_WIDTH-1:0] LP_INFLIGHT_MAX = {INFLIGHT_WIDTH{1'b1}};
  localparam logic [INFLIGHT_WIDTH-1:0] LP_INFLIGHT_ONE = INFLIGHT_WIDTH'(1);

  ht_clear_state_t             r_state;
  logic                        r_head_run;
  logic                        r_data_run;
  logic                        r_head_done;
  logic                        r_data_done;
  logic                        r_init_done;
  logic                        r_busy;
  logic [INFLIGHT_WIDTH-1:0]   r_inflight;
  logic                        r_underflow;

  logic                        w_gate_open;
  logic                        w_task_valid;
  logic                        w_task_ready;
  logic                        w_accept;
  logic                        w_head_seen;
  logic                        w_data_seen;
  logic                        w_pulse_cycle;

  // Gate closes in the same cycle a clear is requested and when the counter is full.
  assign w_gate_open  = (r_state == RUN) && !clear_req_i && (r_inflight != LP_INFLIGHT_MAX);
  assign w_task_valid = w_gate_open & task_if.task_valid_i;
  assign w_task_ready = w_gate_open & task_if.task_ready_i;
  assign w_accept     = w_task_valid & task_if.task_ready_i;

  // Done inputs count together with the sticky flags, so a same-cycle pair completes the wait.
  assign w_head_seen   = r_head_done | head_clear_done_i;
  assign w_data_seen   = r_data_done | data_clear_done_i;
  // The run pulse is only high during the first WAIT_CLR cycle; done inputs there are ignored.
  assign w_pulse_cycle = r_head_run;

  // Sequencing FSM, outstanding-task counter and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= CLR_START;
      r_head_run  <= 1'b0;
      r_data_run  <= 1'b0;
      r_head_done <= 1'b0;
      r_data_done <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
      r_inflight  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_head_run <= 1'b0;
      r_data_run <= 1'b0;

      // Simultaneous accept and result leave the count unchanged.
      unique case ({w_accept, task_if.res_fire_i})
        2'b10: r_inflight <= r_inflight + LP_INFLIGHT_ONE;
        2'b01: begin
          if (r_inflight == '0) begin
            r_underflow <= 1'b1;
          end else begin
            r_inflight <= r_inflight - LP_INFLIGHT_ONE;
          end
        end
        default: begin
        end
      endcase

      unique case (r_state)
        CLR_START: begin
          r_head_done <= 1'b0;
          r_data_done <= 1'b0;
          r_head_run  <= 1'b1;
          r_data_run  <= 1'b1;
          r_state     <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!w_pulse_cycle) begin
            r_head_done <= w_head_seen;
            r_data_done <= w_data_seen;
            if (w_head_seen && w_data_seen) begin
              r_state     <= RUN;
              r_busy      <= 1'b0;
              r_init_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clear_req_i) begin
            r_state <= DRAIN;
            r_busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (r_inflight == '0) begin
            r_state <= CLR_START;
          end
        end
        default: begin
          r_state <= CLR_START;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign task_if.task_valid_o = w_task_valid;
  assign task_if.task_ready_o = w_task_ready;
  assign head_clear_run_o     = r_head_run;
  assign data_clear_run_o     = r_data_run;
  assign init_done_o          = r_init_done;
  assign busy_o               = r_busy;
  assign inflight_o           = r_inflight;
  assign underflow_o          = r_underflow;

endmodule

// File: tb/tb_ht_clear_ctrl.sv
// tb_ht_clear_ctrl: drives a wide (6-bit) and a narrow (2-bit) controller with
// shared stimulus and compares both every cycle against a behavioural model.
module tb_ht_clear_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic tv_in, tr_in, res, clr, hd, dd;

  ht_clear_ctrl_if if_w ();
  ht_clear_ctrl_if if_n ();

  assign if_w.task_valid_i = tv_in;
  assign if_w.task_ready_i = tr_in;
  assign if_w.res_fire_i   = res;
  assign if_n.task_valid_i = tv_in;
  assign if_n.task_ready_i = tr_in;
  assign if_n.res_fire_i   = res;

  logic       hr_w, dr_w, id_w, bs_w, uf_w;
  logic       hr_n, dr_n, id_n, bs_n, uf_n;
  logic [5:0] inf_w;
  logic [1:0] inf_n;

  ht_clear_ctrl #(.INFLIGHT_WIDTH(6)) u_wide (
    .clk_i             (clk),
    .rst_i             (rst),
    .task_if           (if_w),
    .clear_req_i       (clr),
    .head_clear_run_o  (hr_w),
    .head_clear_done_i (hd),
    .data_clear_run_o  (dr_w),
    .data_clear_done_i (dd),
    .init_done_o       (id_w),
    .busy_o            (bs_w),
    .inflight_o        (inf_w),
    .underflow_o       (uf_w)
  );

  ht_clear_ctrl #(.INFLIGHT_WIDTH(2)) u_narrow (
    .clk_i             (clk),
    .rst_i             (rst),
    .task_if           (if_n),
    .clear_req_i       (clr),
    .head_clear_run_o  (hr_n),
    .head_clear_done_i (hd),
    .data_clear_run_o  (dr_n),
    .data_clear_done_i (dd),
    .init_done_o       (id_n),
    .busy_o            (bs_n),
    .inflight_o        (inf_n),
    .underflow_o       (uf_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase names follow the controller's documented modes.
  localparam int P_CLR = 0, P_WAIT = 1, P_RUN = 2, P_DRAIN = 3;
  int m_phase[2], m_age[2], m_inf[2], m_max[2];
  bit m_hs[2], m_ds[2], m_init[2], m_uf[2];

  initial begin
    m_max[0] = 63;
    m_max[1] = 3;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      string tag;
      bit gate, e_tv, e_tr, acc;
      int old_inf;
      tag = (i == 0) ? "w" : "n";
      if (rst) begin
        m_phase[i] = P_CLR; m_age[i] = 0; m_inf[i] = 0;
        m_hs[i] = 0; m_ds[i] = 0; m_init[i] = 0; m_uf[i] = 0;
      end
      gate = (m_phase[i] == P_RUN) && !clr && (m_inf[i] < m_max[i]);
      e_tv = gate && tv_in;
      e_tr = gate && tr_in;
      check({tag, "_tv"},   32'((i == 0) ? if_w.task_valid_o : if_n.task_valid_o), 32'(e_tv));
      check({tag, "_tr"},   32'((i == 0) ? if_w.task_ready_o : if_n.task_ready_o), 32'(e_tr));
      check({tag, "_hrun"}, 32'((i == 0) ? hr_w : hr_n), 32'(m_phase[i] == P_WAIT && m_age[i] == 0));
      check({tag, "_drun"}, 32'((i == 0) ? dr_w : dr_n), 32'(m_phase[i] == P_WAIT && m_age[i] == 0));
      check({tag, "_init"}, 32'((i == 0) ? id_w : id_n), 32'(m_init[i]));
      check({tag, "_busy"}, 32'((i == 0) ? bs_w : bs_n), 32'(m_phase[i] != P_RUN));
      check({tag, "_inf"},  (i == 0) ? 32'(inf_w) : 32'(inf_n), 32'(m_inf[i]));
      check({tag, "_uf"},   32'((i == 0) ? uf_w : uf_n), 32'(m_uf[i]));
      if (!rst) begin
        acc = e_tv && tr_in;
        old_inf = m_inf[i];
        if (acc && !res) m_inf[i]++;
        else if (!acc && res) begin
          if (m_inf[i] == 0) m_uf[i] = 1;
          else m_inf[i]--;
        end
        case (m_phase[i])
          P_CLR: begin
            m_hs[i] = 0; m_ds[i] = 0; m_age[i] = 0; m_phase[i] = P_WAIT;
          end
          P_WAIT: begin
            if (m_age[i] > 0) begin
              m_hs[i] = m_hs[i] || hd;
              m_ds[i] = m_ds[i] || dd;
              if (m_hs[i] && m_ds[i]) begin
                m_phase[i] = P_RUN;
                m_init[i] = 1;
              end
            end
            m_age[i]++;
          end
          P_RUN:   if (clr) m_phase[i] = P_DRAIN;
          default: if (old_inf == 0) m_phase[i] = P_CLR;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv_in = 0; tr_in = 1; res = 0; clr = 0; hd = 0; dd = 0; rst = 1;
    repeat (3) @(posedge clk);
    #1;
    tv_in = 1;
    #1;
    check("rst_busy", 32'(bs_w), 32'd1);
    check("rst_tr",   32'(if_w.task_ready_o), 32'd0);
    check("rst_tv",   32'(if_w.task_valid_o), 32'd0);
    check("rst_init", 32'(id_w), 32'd0);
    check("rst_hrun", 32'(hr_w), 32'd0);
    tv_in = 0;
    rst = 0;

    // Initial clear: head done in WAIT cycle 3, data done in WAIT cycle 7.
    for (int c = 1; c <= 10; c++) begin
      step();
      hd = (c == 4);
      dd = (c == 8);
      #1;
      if (c == 1) begin
        check("init_hrun_hi", 32'(hr_w), 32'd1);
        check("init_drun_hi", 32'(dr_w), 32'd1);
      end
      if (c == 2) check("init_hrun_lo", 32'(hr_w), 32'd0);
      if (c == 8) begin
        check("init_pre_done", 32'(id_w), 32'd0);
        check("init_pre_busy", 32'(bs_w), 32'd1);
        check("init_pre_tr",   32'(if_w.task_ready_o), 32'd0);
      end
      if (c == 9) begin
        check("init_done", 32'(id_w), 32'd1);
        check("init_busy", 32'(bs_w), 32'd0);
        check("init_tr",   32'(if_w.task_ready_o), 32'd1);
      end
    end

    // Five accepts, then results; narrow saturates at 3.
    step(); tv_in = 1;
    repeat (4) step();
    step(); tv_in = 0;
    #1;
    check("acc5_w_inf", 32'(inf_w), 32'd5);
    check("full_n_inf", 32'(inf_n), 32'd3);
    check("full_n_tr",  32'(if_n.task_ready_o), 32'd0);
    res = 1;
    step(); res = 0;
    #1;
    check("reopen_n_tr",  32'(if_n.task_ready_o), 32'd1);
    check("reopen_n_inf", 32'(inf_n), 32'd2);
    check("dec_w_inf",    32'(inf_w), 32'd4);
    tv_in = 1; res = 1;
    step(); tv_in = 0; res = 0;
    #1;
    check("both_w_inf", 32'(inf_w), 32'd4);
    check("both_n_inf", 32'(inf_n), 32'd2);
    step(); res = 1;
    repeat (3) step();
    step(); res = 0;
    #1;
    check("drain_w_inf", 32'(inf_w), 32'd0);
    check("drain_w_uf",  32'(uf_w), 32'd0);
    check("drain_n_uf",  32'(uf_n), 32'd1);

    // Runtime clear with four outstanding tasks; offer in the request cycle is refused.
    step(); tv_in = 1;
    repeat (3) step();
    step(); tv_in = 1; clr = 1;
    #1;
    check("req_w_inf", 32'(inf_w), 32'd4);
    check("req_w_tv",  32'(if_w.task_valid_o), 32'd0);
    check("req_w_tr",  32'(if_w.task_ready_o), 32'd0);
    step(); clr = 0; tv_in = 0;
    #1;
    check("drain_busy", 32'(bs_w), 32'd1);
    check("drain_inf",  32'(inf_w), 32'd4);
    res = 1;
    repeat (3) step();
    step(); res = 0; hd = 1; dd = 1;
    repeat (5) step();
    step(); hd = 0; dd = 0;
    #1;
    check("reclr_init", 32'(id_w), 32'd1);
    check("reclr_busy", 32'(bs_w), 32'd0);

    // Clear request held high through the whole clear.
    step(); clr = 1;
    repeat (4) step();
    step(); hd = 1; dd = 1;
    step(); hd = 0; dd = 0; tv_in = 1;
    #1;
    check("lvl_run_busy", 32'(bs_w), 32'd0);
    check("lvl_run_tv",   32'(if_w.task_valid_o), 32'd0);
    step(); tv_in = 0;
    #1;
    check("lvl_redrain", 32'(bs_w), 32'd1);
    clr = 0;
    repeat (3) step();
    hd = 1; dd = 1;
    repeat (3) step();
    step(); hd = 0; dd = 0;
    #1;
    check("lvl_back_run", 32'(bs_w), 32'd0);

    // Reset asserted in DRAIN with two outstanding tasks.
    step(); tv_in = 1;
    step();
    step(); tv_in = 0; clr = 1;
    step(); clr = 0;
    #1;
    check("pre_rst_inf", 32'(inf_w), 32'd2);
    rst = 1;
    #1;
    check("arst_inf",  32'(inf_w), 32'd0);
    check("arst_init", 32'(id_w), 32'd0);
    check("arst_busy", 32'(bs_w), 32'd1);
    step();
    step(); rst = 0;
    repeat (3) step();
    hd = 1; dd = 1;
    step(); hd = 0; dd = 0; res = 1;
    #1;
    check("post_rst_uf0", 32'(uf_w), 32'd0);
    step(); res = 0;
    #1;
    check("post_rst_uf1", 32'(uf_w), 32'd1);
    check("post_rst_inf", 32'(inf_w), 32'd0);

    // Randomised traffic, requests, completions and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step();
      tv_in = 1'($urandom_range(0, 1));
      tr_in = ($urandom_range(0, 3) != 0);
      res   = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      hd    = ($urandom_range(0, 5) == 0);
      dd    = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 499) == 0);
    end
    step();
    rst = 0; tv_in = 0; res = 0; clr = 0; hd = 0; dd = 0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
